// File: rtl/pkt_merge_pkg.sv
// Shared types and constants for the two-port packet merge arbiter.
package pkt_merge_pkg;

  localparam int unsigned PktDw     = 153;
  localparam int unsigned PktEopBit = 152;

  typedef enum logic [1:0] {
    StIdle,
    StBusy0,
    StBusy1
  } state_e;

  typedef logic port_id_t;

endpackage

// File: rtl/pkt_merge_obuf.sv
// Single-entry output register: decouples output-FIFO backpressure from input dequeue.
module pkt_merge_obuf
  import pkt_merge_pkg::*;
#(
  parameter int unsigned DW = PktDw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          full_ni,
  output logic          enq_o,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q;

  assign enq_o   = valid_q & full_ni;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  // A load in the same cycle as an enqueue replaces the entry and keeps it valid.
  always_comb begin
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;
    end else if (enq_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/pkt_merge_arb.sv
// Packet-granular round-robin merge of two input FIFOs into one output FIFO.
module pkt_merge_arb
  import pkt_merge_pkg::*;
#(
  parameter int unsigned DW      = PktDw,
  parameter int unsigned EOP_BIT = PktEopBit,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned CW      = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] i0_D,
  input  logic          i0_EMPTY_N,
  output logic          i0_DEQ,
  input  logic [DW-1:0] i1_D,
  input  logic          i1_EMPTY_N,
  output logic          i1_DEQ,
  output logic [DW-1:0] o_D_IN,
  output logic          o_ENQ,
  input  logic          o_FULL_N,
  output logic [CW-1:0] pkt_cnt0,
  output logic [CW-1:0] pkt_cnt1,
  output logic          err_len
);

  localparam int unsigned WcntW = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  port_id_t         last_q;
  port_id_t         cur;
  logic [WcntW-1:0] wcnt_q;
  logic [CW-1:0]    cnt0_q, cnt1_q;
  logic             err_q;
  logic             ovalid, load_ok, deq, eop, at_max, release_pkt;
  logic [DW-1:0]    deq_word;

  assign load_ok     = ~ovalid | o_FULL_N;
  assign deq         = i0_DEQ | i1_DEQ;
  assign cur         = (state_q == StBusy1);
  assign deq_word    = cur ? i1_D : i0_D;
  assign eop         = deq_word[EOP_BIT];
  assign at_max      = (wcnt_q == WcntW'(MAX_LEN - 1));
  assign release_pkt = deq & (eop | at_max);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // On a tie the port that was not served last wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i0_EMPTY_N && i1_EMPTY_N) begin
          state_d = last_q ? StBusy0 : StBusy1;
        end else if (i0_EMPTY_N) begin
          state_d = StBusy0;
        end else if (i1_EMPTY_N) begin
          state_d = StBusy1;
        end
      end
      StBusy0, StBusy1: begin
        if (release_pkt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    i0_DEQ = 1'b0;
    i1_DEQ = 1'b0;
    unique case (state_q)
      StBusy0: i0_DEQ = i0_EMPTY_N & load_ok;
      StBusy1: i1_DEQ = i1_EMPTY_N & load_ok;
      default: ;
    endcase
  end

  // A release without EOP is a forced cut: flagged, not counted as a packet.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q <= 1'b1;
      wcnt_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      err_q  <= 1'b0;
    end else if (deq) begin
      if (release_pkt) begin
        wcnt_q <= '0;
        last_q <= cur;
        if (!eop) begin
          err_q <= 1'b1;
        end else if (cur) begin
          cnt1_q <= cnt1_q + 1'b1;
        end else begin
          cnt0_q <= cnt0_q + 1'b1;
        end
      end else begin
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
  assign err_len  = err_q;

  pkt_merge_obuf #(
    .DW(DW)
  ) u_obuf (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .load_i  (deq),
    .data_i  (deq_word),
    .full_ni (o_FULL_N),
    .enq_o   (o_ENQ),
    .data_o  (o_D_IN),
    .valid_o (ovalid)
  );

endmodule
